gate_unit_pipe: RTL

//  Parametrised, registered successor to the team's 2-input OR gate: W-bit bitwise logic unit with

---
 rtl/gate_unit_pipe_pkg.sv | 27 ++
 rtl/gate_unit_pipe_if.sv | 32 +++
 rtl/gate_unit_pipe_alu.sv | 28 ++
 rtl/gate_unit_pipe.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/gate_unit_pipe_pkg.sv
// Package gate_pkg: shared types for the gate_unit_pipe slice.
//   op_t    : 3-bit op code (OR, AND, XOR, NOR, NAND, XNOR, PASS_A, NOT_A)
//   state_t : reduce FSM states (IDLE, ACCUM)
//   is_binary(): true for ops that fold across beats in reduce mode (0-5)
package gate_pkg;

   typedef enum logic [2:0] {
      OP_OR     = 3'd0,
      OP_AND    = 3'd1,
      OP_XOR    = 3'd2,
      OP_NOR    = 3'd3,
      OP_NAND   = 3'd4,
      OP_XNOR   = 3'd5,
      OP_PASS_A = 3'd6,
      OP_NOT_A  = 3'd7
   } op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   function automatic logic is_binary(op_t op);
      return (op <= OP_XNOR);
   endfunction

endpackage

// File: rtl/gate_unit_pipe_if.sv
// Interface gate_unit_pipe_if: input beat and output result channels.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; the sender holds valid and payload stable until then,
// and ready may depend combinationally on the receiver's state.
//   in_*  : beat channel (in_valid/in_ready, in_a, in_b, in_op, in_mode, in_last)
//   out_* : result channel (out_valid/out_ready, out_c) plus out_err pulse
// modport master: stimulus side; modport slave: the unit.
interface gate_unit_pipe_if #(
   parameter int W = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [2:0]   in_op;
   logic         in_mode;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_c;
   logic         out_err;

   modport master (
      output in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
      input  in_ready, out_valid, out_c, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
      output in_ready, out_valid, out_c, out_err
   );
endinterface

// File: rtl/gate_unit_pipe_alu.sv
// Module gate_alu: combinational W-bit bitwise logic unit.
//   x, y : operands (y unused by PASS_A / NOT_A)
//   op   : op code
//   z    : result
module gate_alu
   import gate_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  op_t          op,
   output logic [W-1:0] z
);
   always_comb begin
      z = '0;
      case (op)
         OP_OR:     z = x | y;
         OP_AND:    z = x & y;
         OP_XOR:    z = x ^ y;
         OP_NOR:    z = ~(x | y);
         OP_NAND:   z = ~(x & y);
         OP_XNOR:   z = ~(x ^ y);
         OP_PASS_A: z = x;
         OP_NOT_A:  z = ~x;
      endcase
   end
endmodule

// File: rtl/gate_unit_pipe.sv
// Module gate_unit_pipe: registered W-bit logic unit with pairwise and
// packet-reduce modes behind valid/ready handshakes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gate_unit_pipe_if.slave (beat in, result out, out_err)
//   fsm_state  : current reduce FSM state (debug visibility)
//   stat_pkts  : delivered-result counter, saturating; present only when
//                the macro GATE_STATS_EN is defined
module gate_unit_pipe
   import gate_pkg::*;
#(
   parameter int W     = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   gate_unit_pipe_if.slave     bus,
   output state_t              fsm_state
`ifdef GATE_STATS_EN
   ,
   output logic [CNT_W-1:0]    stat_pkts
`endif
);
   state_t       state_q, state_d;
   op_t          op_q;
   op_t          op_in;
   logic [W-1:0] acc_q, acc_d;
   logic         out_valid_q;
   logic [W-1:0] out_c_q;
   logic         out_err_q;

   logic         accept;
   logic         reduce_beat;
   logic         mismatch;
   logic         fold;
   logic         emit;
   logic         err_d;
   logic         load_op;
   logic [W-1:0] res;
   logic [W-1:0] alu_x, alu_y, alu_z;
   op_t          alu_op;

   assign op_in       = op_t'(bus.in_op);
   // Single output register: free to accept whenever it is empty or draining.
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign accept      = bus.in_valid && bus.in_ready;
   // PASS_A / NOT_A have no fold meaning, so they run pairwise even in reduce mode.
   assign reduce_beat = bus.in_mode && is_binary(op_in);
   // Only reduce packets enter ACCUM, so a latched mode is always 1.
   assign mismatch    = !bus.in_mode || (op_in != op_q);
   assign fold        = (state_q == ACCUM) && !mismatch;

   // One ALU shared by both paths: fold uses (acc, in_a, latched op).
   always_comb begin
      alu_x  = bus.in_a;
      alu_y  = bus.in_b;
      alu_op = op_in;
      if (fold) begin
         alu_x  = acc_q;
         alu_y  = bus.in_a;
         alu_op = op_q;
      end
   end

   gate_alu #(.W(W)) u_alu (
      .x  (alu_x),
      .y  (alu_y),
      .op (alu_op),
      .z  (alu_z)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      emit    = 1'b0;
      res     = alu_z;
      err_d   = 1'b0;
      load_op = 1'b0;
      if (accept) begin
         if (fold) begin
            if (bus.in_last) begin
               emit    = 1'b1;
               state_d = IDLE;
            end else begin
               acc_d = alu_z;
            end
         end else begin
            // A foreign beat in ACCUM aborts the packet and restarts from it.
            err_d   = (state_q == ACCUM);
            state_d = IDLE;
            if (reduce_beat) begin
               acc_d   = bus.in_a;
               load_op = 1'b1;
               if (bus.in_last) begin
                  emit = 1'b1;
                  res  = bus.in_a;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               emit = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_OR;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         out_err_q <= err_d;
         if (load_op) op_q <= op_in;
         if (emit) begin
            out_valid_q <= 1'b1;
            out_c_q     <= res;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_c     = out_c_q;
   assign bus.out_err   = out_err_q;
   assign fsm_state     = state_q;

`ifdef GATE_STATS_EN
   logic [CNT_W-1:0] pkts_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkts_q <= '0;
      end else if (out_valid_q && bus.out_ready && (pkts_q != {CNT_W{1'b1}})) begin
         pkts_q <= pkts_q + 1'b1;
      end
   end

   assign stat_pkts = pkts_q;
`endif
endmodule
